rob_commit: RTL

In-order reorder buffer for the out-of-order core. It allocates one entry per dispatched instruction and returns the ROB index that the RAT records as the destination tag. It collects writeback results out of order and retires at most one completed head entry per cycle. Retirement drives the commit half of the CDB: regf_we, commit_rd_addr, commit_data and flush, which the RAT/ARF consumes to write architectural state and clear rename state.

---
 rtl/rob_commit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/rob_commit.sv
// rob_commit: in-order reorder buffer with out-of-order writeback and single-entry retirement.
// Optional perf counters are built when ROB_PERF_CNT_EN is defined.
module rob_commit #(
    parameter int ROB_DEPTH     = 32,
    parameter int ROB_IDX_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid,
    input  logic [4:0]               alloc_rd_addr,
    output logic                     alloc_ready,
    output logic [ROB_IDX_WIDTH-1:0] alloc_rob_idx,
    input  logic                     wb_valid,
    input  logic [ROB_IDX_WIDTH-1:0] wb_rob_idx,
    input  logic [31:0]              wb_data,
    input  logic                     wb_mispredict,
    input  logic [31:0]              wb_target,
    output logic                     regf_we,
    output logic [4:0]               commit_rd_addr,
    output logic [31:0]              commit_data,
    output logic [ROB_IDX_WIDTH-1:0] commit_rob_idx,
    output logic                     flush,
    output logic [31:0]              flush_pc,
    output logic [ROB_IDX_WIDTH:0]   occupancy,
    output logic [31:0]              perf_commits,
    output logic [31:0]              perf_flushes
);
    logic [ROB_DEPTH-1:0]     valid_q, done_q, mp_q;
    logic [4:0]               rd_q   [ROB_DEPTH];
    logic [31:0]              data_q [ROB_DEPTH];
    logic [31:0]              tgt_q  [ROB_DEPTH];
    logic [ROB_IDX_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROB_IDX_WIDTH:0]   count_q, count_d;
    logic                     commit_fire, flush_pending, alloc_fire, wb_hit;

    assign commit_fire   = valid_q[head_q] && done_q[head_q];
    assign flush_pending = commit_fire && mp_q[head_q];
    assign alloc_ready   = (count_q != (ROB_IDX_WIDTH+1)'(ROB_DEPTH)) && !flush_pending;
    assign alloc_fire    = alloc_valid && alloc_ready;
    assign wb_hit        = wb_valid && valid_q[wb_rob_idx];
    assign alloc_rob_idx = tail_q;
    assign occupancy     = count_q;

    always_comb begin
        head_d  = flush_pending ? '0 : head_q + ROB_IDX_WIDTH'(commit_fire);
        tail_d  = flush_pending ? '0 : tail_q + ROB_IDX_WIDTH'(alloc_fire);
        count_d = flush_pending ? '0 : count_q + (ROB_IDX_WIDTH+1)'(alloc_fire)
                                              - (ROB_IDX_WIDTH+1)'(commit_fire);
    end

    // A mispredict commit wipes every valid bit, which also discards any same-cycle writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            done_q  <= '0;
            mp_q    <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (wb_hit) begin
                done_q[wb_rob_idx] <= 1'b1;
                mp_q[wb_rob_idx]   <= wb_mispredict;
            end
            if (alloc_fire) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                mp_q[tail_q]    <= 1'b0;
            end
            if (commit_fire)
                valid_q[head_q] <= 1'b0;
            if (flush_pending)
                valid_q <= '0;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wb_hit) begin
            data_q[wb_rob_idx] <= wb_data;
            tgt_q[wb_rob_idx]  <= wb_target;
        end
        if (alloc_fire)
            rd_q[tail_q] <= alloc_rd_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regf_we        <= 1'b0;
            flush          <= 1'b0;
            commit_rd_addr <= '0;
            commit_data    <= '0;
            commit_rob_idx <= '0;
            flush_pc       <= '0;
        end else begin
            regf_we <= commit_fire && (rd_q[head_q] != 5'd0);
            flush   <= flush_pending;
            if (commit_fire) begin
                commit_rd_addr <= rd_q[head_q];
                commit_data    <= data_q[head_q];
                commit_rob_idx <= head_q;
            end
            if (flush_pending)
                flush_pc <= tgt_q[head_q];
        end
    end

`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_commits_q, perf_flushes_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_commits_q <= '0;
            perf_flushes_q <= '0;
        end else begin
            perf_commits_q <= perf_commits_q + 32'(commit_fire);
            perf_flushes_q <= perf_flushes_q + 32'(flush_pending);
        end
    end
    assign perf_commits = perf_commits_q;
    assign perf_flushes = perf_flushes_q;
`else
    assign perf_commits = '0;
    assign perf_flushes = '0;
`endif
endmodule
